// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake bundle between producer, FIFO and UART transmitter.
// The master side drives upstream data and downstream ready; the FIFO is the slave.
interface uart_tx_fifo_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding a UART transmitter, with registered
// valid/ready/almost-full flags, a sticky overflow flag and a synchronous flush.
module uart_tx_fifo #(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  uart_tx_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     almost_full,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0))
    $error("uart_tx_fifo: DEPTH must be a power of two in 4..256");
  if ((ALMOST_FULL_LVL < 1) || (ALMOST_FULL_LVL > DEPTH))
    $error("uart_tx_fifo: ALMOST_FULL_LVL must be 1..DEPTH");

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mvld_q, mvld_d, srdy_q, srdy_d;
  logic          afull_q, afull_d, ovf_q, ovf_d;
  logic          push, pop;

  // Handshakes use the registered flags, so a full FIFO refuses a push even
  // when a pop happens on the same edge.
  assign push = bus.s_axis_tvalid && srdy_q && !flush;
  assign pop  = mvld_q && bus.m_axis_tready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.s_axis_tvalid && !srdy_q) ovf_d = 1'b1;
    end
    mvld_d  = (count_d != '0);
    srdy_d  = (count_d != CW'(DEPTH));
    afull_d = (count_d >= CW'(ALMOST_FULL_LVL));
  end

  // Ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mvld_q   <= 1'b0;
      srdy_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mvld_q   <= mvld_d;
      srdy_q   <= srdy_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale entries are never visible because valid gates them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_axis_tdata;
  end

  assign bus.m_axis_tdata  = mem_q[rd_ptr_q];
  assign bus.m_axis_tvalid = mvld_q;
  assign bus.s_axis_tready = srdy_q;
  assign fifo_count        = count_q;
  assign almost_full       = afull_q;
  assign overflow          = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue-based model is checked against the
// DUT after every edge, plus literal expectations at the interesting points.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic almost_full, overflow;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL_LVL(AFL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave),
    .fifo_count(fifo_count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] q[$];
  bit rdy_m = 1'b0;
  bit ovf_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("m_tvalid", 32'(bus.m_axis_tvalid), 32'(q.size() != 0));
    if (q.size() != 0) chk("m_tdata", 32'(bus.m_axis_tdata), 32'(q[0]));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("s_tready", 32'(bus.s_axis_tready), 32'(rdy_m));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
    chk("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic step(input bit tv, input logic [7:0] td, input bit mr, input bit fl);
    bit push, pop;
    bus.s_axis_tvalid = tv;
    bus.s_axis_tdata  = td;
    bus.m_axis_tready = mr;
    flush             = fl;
    @(posedge clk);
    push = tv && rdy_m && !fl;
    pop  = (q.size() != 0) && mr && !fl;
    if (fl) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (tv && !rdy_m) ovf_m = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(td);
    end
    rdy_m = (q.size() != DEPTH);
    #1;
    cmp_all();
  endtask

  task automatic model_reset();
    q.delete();
    rdy_m = 1'b0;
    ovf_m = 1'b0;
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cmp_all();
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ready", 32'(bus.s_axis_tready), 32'd0);
    rst_n = 1'b1;

    // First edge after release only raises ready
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("first_edge_ready", 32'(bus.s_axis_tready), 32'd1);

    // Single push, held while the transmitter is busy
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("push55_data", 32'(bus.m_axis_tdata), 32'h55);
    chk("push55_count", 32'(fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("push55_stable", 32'(bus.m_axis_tdata), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop55_empty", 32'(bus.m_axis_tvalid), 32'd0);

    // Fill to full, watch almost_full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AFL - 2) chk("afull_at_11", 32'(almost_full), 32'd0);
      if (i == AFL - 1) chk("afull_at_12", 32'(almost_full), 32'd1);
    end
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_ready", 32'(bus.s_axis_tready), 32'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_count", 32'(fifo_count), 32'd16);

    // Pop and push together while full: push refused
    chk("full_head", 32'(bus.m_axis_tdata), 32'h00);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("fullpp_count", 32'(fifo_count), 32'd15);
    chk("fullpp_ready", 32'(bus.s_axis_tready), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_order", 32'(bus.m_axis_tdata), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(bus.m_axis_tvalid), 32'd0);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_clr_ovf", 32'(overflow), 32'd0);

    // Streaming across two pointer wraps
    step(1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      chk("stream_count", 32'(fifo_count), 32'd1);
      chk("stream_data", 32'(bus.m_axis_tdata), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_end", 32'(bus.m_axis_tvalid), 32'd0);

    // Flush beats a concurrent push
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    chk("preflush_count", 32'(fifo_count), 32'd5);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_valid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_discard", 32'(bus.m_axis_tvalid), 32'd0);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 7; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    chk("prereset_count", 32'(fifo_count), 32'd7);
    bus.s_axis_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    chk("async_count", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h3D, 1'b0, 1'b0);
    chk("postreset_head", 32'(bus.m_axis_tdata), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("postreset_next", 32'(bus.m_axis_tdata), 32'h3D);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
